// File: rtl/cabac_bina_bits_reader_if.sv
// Stream-word / look-ahead / consume bus of the CABAC bitstream reader.
// Optional pos_o output appears when CABAC_BINA_RD_POS_EN is defined.
interface cabac_bina_bits_reader_if;
    logic        flush_i;
    logic [31:0] word_i;
    logic        word_val_i;
    logic        word_rdy_o;
    logic [15:0] win_o;
    logic        win_val_o;
    logic [4:0]  lead0_o;
    logic [6:0]  cnt_o;
    logic        consume_i;
    logic [4:0]  consume_len_i;
    logic        err_o;
`ifdef CABAC_BINA_RD_POS_EN
    logic [31:0] pos_o;
`endif

    // Fetch unit / bin parser side
    modport master (
        output flush_i, word_i, word_val_i, consume_i, consume_len_i,
        input  word_rdy_o, win_o, win_val_o, lead0_o, cnt_o, err_o
`ifdef CABAC_BINA_RD_POS_EN
        , input pos_o
`endif
    );

    modport slave (
        input  flush_i, word_i, word_val_i, consume_i, consume_len_i,
        output word_rdy_o, win_o, win_val_o, lead0_o, cnt_o, err_o
`ifdef CABAC_BINA_RD_POS_EN
        , output pos_o
`endif
    );
endinterface

// File: rtl/cabac_bina_bits_reader.sv
// CABAC bitstream reader: 64-bit left-aligned bit buffer fed with 32-bit words, 16-bit look-ahead.
// Optional macro CABAC_BINA_RD_POS_EN adds a consumed-bit position counter (pos_o).
module cabac_bina_bits_reader #(
    parameter int WORD_W = 32,
    parameter int WIN_W  = 16,
    parameter int BUF_W  = 64
) (
    input logic                      clk,
    input logic                      rst,
    cabac_bina_bits_reader_if.slave  bus
);
    localparam int CNT_W = 7;

    function automatic logic [4:0] lead0_of(input logic [WIN_W-1:0] w);
        logic [4:0] n;
        logic       found;
        n     = 5'(WIN_W);
        found = 1'b0;
        for (int i = WIN_W - 1; i >= 0; i--) begin
            if (!found && w[i]) begin
                n     = 5'(WIN_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic [BUF_W-1:0] buf_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic             err_p0;
`ifdef CABAC_BINA_RD_POS_EN
    logic [31:0]      pos_p0;
`endif

    logic             rdy;
    logic             load;
    logic             win_val;
    logic             cons_req;
    logic             legal;
    logic             illegal;
    logic [4:0]       take;
    logic [CNT_W-1:0] cnt_after;
    logic [CNT_W-1:0] cnt_nxt;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] placed;
    logic [BUF_W-1:0] buf_nxt;

    always_comb begin
        rdy      = !rst && !bus.flush_i && (cnt_p0 <= CNT_W'(WORD_W));
        load     = bus.word_val_i && rdy;
        win_val  = (cnt_p0 >= CNT_W'(WIN_W));
        cons_req = bus.consume_i && !bus.flush_i;
        legal    = cons_req && win_val && (bus.consume_len_i <= 5'(WIN_W));
        illegal  = cons_req && !legal;
        take     = legal ? bus.consume_len_i : 5'd0;
        // The new word lands directly after whatever survives this cycle's consume
        cnt_after = cnt_p0 - {2'b00, take};
        shifted   = buf_p0 << take;
        placed    = load ? ({bus.word_i, {WORD_W{1'b0}}} >> cnt_after) : '0;
        buf_nxt   = shifted | placed;
        cnt_nxt   = cnt_after + (load ? CNT_W'(WORD_W) : '0);
    end

    // Stage p0: buffer, fill count and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_p0 <= '0;
            cnt_p0 <= '0;
            err_p0 <= 1'b0;
        end else if (bus.flush_i) begin
            buf_p0 <= '0;
            cnt_p0 <= '0;
        end else begin
            buf_p0 <= buf_nxt;
            cnt_p0 <= cnt_nxt;
            err_p0 <= err_p0 | illegal;
        end
    end

`ifdef CABAC_BINA_RD_POS_EN
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) pos_p0 <= '0;
        else                    pos_p0 <= pos_p0 + {27'd0, take};
    end
    assign bus.pos_o = pos_p0;
`endif

    assign bus.word_rdy_o = rdy;
    assign bus.win_o      = buf_p0[BUF_W-1 -: WIN_W];
    assign bus.win_val_o  = win_val;
    assign bus.lead0_o    = lead0_of(buf_p0[BUF_W-1 -: WIN_W]);
    assign bus.cnt_o      = cnt_p0;
    assign bus.err_o      = err_p0;
endmodule
